execute_alu_mreg: RTL and testbench

Execute-stage back end of the Y86-64 pipeline, directly downstream of the E-stage operand-select block.
- Consumes that block's aluA/aluB/fun outputs and computes valE.
- Owns the condition-code register (ZF/SF/OF) and evaluates jXX/cmovXX conditions.
- Holds the E→M pipeline register that feeds the memory stage.
- Publishes combinational e_valE/e_dstE for forwarding to decode.

---
 rtl/execute_alu_mreg_if.sv | 45 ++++
 rtl/execute_alu_mreg.sv | 144 ++++++++++++++
 tb/tb_execute_alu_mreg.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_alu_mreg_if.sv
// Bundle between E-stage operand select / pipeline control and the execute back end.
// The master drives the E-stage inputs; the slave (execute_alu_mreg) returns its results.
// The E->M register outputs and the combinational forwarding outputs are all carried here.
interface execute_alu_mreg_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] aluA_i;
  logic [DATA_W-1:0] aluB_i;
  logic [3:0]        fun_i;
  logic [3:0]        E_icode_i;
  logic [3:0]        E_ifun_i;
  logic [2:0]        E_stat_i;
  logic [DATA_W-1:0] E_valA_i;
  logic [3:0]        E_dstE_i;
  logic [3:0]        E_dstM_i;
  logic [2:0]        m_stat_i;
  logic [2:0]        W_stat_i;
  logic              M_bubble_i;

  logic [DATA_W-1:0] e_valE_o;
  logic [3:0]        e_dstE_o;
  logic              e_cnd_o;
  logic [2:0]        cc_o;
  logic [2:0]        M_stat_o;
  logic [3:0]        M_icode_o;
  logic              M_cnd_o;
  logic [DATA_W-1:0] M_valE_o;
  logic [DATA_W-1:0] M_valA_o;
  logic [3:0]        M_dstE_o;
  logic [3:0]        M_dstM_o;

  modport master (
    output aluA_i, aluB_i, fun_i, E_icode_i, E_ifun_i, E_stat_i, E_valA_i,
           E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
    input  e_valE_o, e_dstE_o, e_cnd_o, cc_o, M_stat_o, M_icode_o, M_cnd_o,
           M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
  );

  modport slave (
    input  aluA_i, aluB_i, fun_i, E_icode_i, E_ifun_i, E_stat_i, E_valA_i,
           E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
    output e_valE_o, e_dstE_o, e_cnd_o, cc_o, M_stat_o, M_icode_o, M_cnd_o,
           M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
  );
endinterface

// File: rtl/execute_alu_mreg.sv
// Y86-64 execute back end: ALU, condition codes, jXX/cmovXX evaluation, E->M pipeline register.
// Latency: e_valE/e_dstE/e_cnd combinational; CC and M register one cycle.
// Backpressure: none; the stall unit controls flow through M_bubble_i and the m/W status gating.
module execute_alu_mreg #(
  parameter int          DATA_W = 64,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  execute_alu_mreg_if.slave bus
);

  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] ICODE_CXX = 4'h2;
  localparam logic [3:0] ICODE_OPQ = 4'h6;
  localparam logic [3:0] ICODE_JXX = 4'h7;
  localparam logic [2:0] STAT_AOK  = 3'd1;
  localparam logic [2:0] STAT_HLT  = 3'd2;
  localparam logic [2:0] STAT_ADR  = 3'd3;
  localparam logic [2:0] STAT_INS  = 3'd4;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic              cnd;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } mreg_t;

  localparam mreg_t MREG_BUBBLE = '{
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    cnd:   1'b0,
    val_e: '0,
    val_a: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  logic [DATA_W-1:0] alu_res;
  logic              new_zf;
  logic              new_sf;
  logic              new_of;
  logic              set_cc;
  logic [2:0]        cc_q;
  logic              cond;
  logic              cnd;
  logic [3:0]        dst_e_eff;
  mreg_t             mreg_q;

  function automatic logic stat_exception(input logic [2:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

  // ALU result (B op A) and the flags this result would produce
  always_comb begin
    alu_res = '0;
    new_of  = 1'b0;
    case (bus.fun_i)
      4'd0: alu_res = bus.aluB_i + bus.aluA_i;
      4'd1: alu_res = bus.aluB_i - bus.aluA_i;
      4'd2: alu_res = bus.aluB_i & bus.aluA_i;
      4'd3: alu_res = bus.aluB_i ^ bus.aluA_i;
      default: alu_res = '0;
    endcase
    new_zf = (alu_res == '0);
    new_sf = alu_res[DATA_W-1];
    case (bus.fun_i)
      4'd0: new_of = (bus.aluA_i[DATA_W-1] == bus.aluB_i[DATA_W-1]) &&
                     (alu_res[DATA_W-1] != bus.aluB_i[DATA_W-1]);
      4'd1: new_of = (bus.aluA_i[DATA_W-1] != bus.aluB_i[DATA_W-1]) &&
                     (alu_res[DATA_W-1] != bus.aluB_i[DATA_W-1]);
      default: new_of = 1'b0;
    endcase
  end

  // Only an OPQ updates CC, and not while an older instruction downstream has faulted
  assign set_cc = (bus.E_icode_i == ICODE_OPQ) &&
                  !stat_exception(bus.m_stat_i) &&
                  !stat_exception(bus.W_stat_i);

  // Condition-code register {ZF,SF,OF}; resets to "zero result"
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cc_q <= 3'b100;
    end else if (set_cc) begin
      cc_q <= {new_zf, new_sf, new_of};
    end
  end

  // Branch/move condition from the registered CC, so an OPQ directly ahead is already visible
  always_comb begin
    cond = 1'b0;
    case (bus.E_ifun_i)
      4'd0: cond = 1'b1;
      4'd1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'd2: cond = cc_q[1] ^ cc_q[0];
      4'd3: cond = cc_q[2];
      4'd4: cond = !cc_q[2];
      4'd5: cond = !(cc_q[1] ^ cc_q[0]);
      4'd6: cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cond = 1'b0;
    endcase
  end

  assign cnd = ((bus.E_icode_i == ICODE_CXX) || (bus.E_icode_i == ICODE_JXX)) && cond;

  // A cmovXX that is not taken must not write its destination
  assign dst_e_eff = ((bus.E_icode_i == ICODE_CXX) && !cnd) ? RNONE : bus.E_dstE_i;

  // E->M pipeline register; bubble overrides the normal load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mreg_q <= MREG_BUBBLE;
    end else if (bus.M_bubble_i) begin
      mreg_q <= MREG_BUBBLE;
    end else begin
      mreg_q <= '{
        stat:  bus.E_stat_i,
        icode: bus.E_icode_i,
        cnd:   cnd,
        val_e: alu_res,
        val_a: bus.E_valA_i,
        dst_e: dst_e_eff,
        dst_m: bus.E_dstM_i
      };
    end
  end

  assign bus.e_valE_o  = alu_res;
  assign bus.e_dstE_o  = dst_e_eff;
  assign bus.e_cnd_o   = cnd;
  assign bus.cc_o      = cc_q;
  assign bus.M_stat_o  = mreg_q.stat;
  assign bus.M_icode_o = mreg_q.icode;
  assign bus.M_cnd_o   = mreg_q.cnd;
  assign bus.M_valE_o  = mreg_q.val_e;
  assign bus.M_valA_o  = mreg_q.val_a;
  assign bus.M_dstE_o  = mreg_q.dst_e;
  assign bus.M_dstM_o  = mreg_q.dst_m;

endmodule

// File: tb/tb_execute_alu_mreg.sv
// Bench for execute_alu_mreg: ALU vector table, hand sequences for CC/condition/bubble/reset,
// then randomized instructions against an arithmetic reference model.
module tb_execute_alu_mreg;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;

  execute_alu_mreg_if #(.DATA_W(64)) bus ();

  execute_alu_mreg #(.DATA_W(64), .RNONE(4'hF)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_t;

  typedef struct {
    logic [3:0]  fun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_val;
    logic [2:0]  exp_cc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [2:0] cc_m;
  m_t         m_m;
  m_t         bubble_m;

  logic [63:0] obs_val;
  logic [3:0]  obs_dst;
  logic        obs_cnd;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
    case (f)
      4'd0: return b + a;
      4'd1: return b - a;
      4'd2: return b & a;
      4'd3: return b ^ a;
      default: return 64'd0;
    endcase
  endfunction

  // Overflow means the exact signed answer differs from the 64-bit result read as signed
  function automatic logic [2:0] ref_flags(input logic [3:0] f, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] r;
    logic signed [65:0] ea, eb, exact, got;
    logic of;
    r = ref_alu(f, a, b);
    ea = $signed({{2{a[63]}}, a});
    eb = $signed({{2{b[63]}}, b});
    got = $signed({{2{r[63]}}, r});
    of = 1'b0;
    if (f == 4'd0) begin
      exact = eb + ea;
      of = (exact != got);
    end else if (f == 4'd1) begin
      exact = eb - ea;
      of = (exact != got);
    end
    return {(r == 64'd0), r[63], of};
  endfunction

  function automatic logic ref_cond(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_exc(input logic [2:0] s);
    return s == 3'd2 || s == 3'd3 || s == 3'd4;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_cc"},    {61'd0, bus.cc_o},      {61'd0, cc_m});
    check({tag, "_Mstat"}, {61'd0, bus.M_stat_o},  {61'd0, m_m.stat});
    check({tag, "_Micode"},{60'd0, bus.M_icode_o}, {60'd0, m_m.icode});
    check({tag, "_Mcnd"},  {63'd0, bus.M_cnd_o},   {63'd0, m_m.cnd});
    check({tag, "_MvalE"}, bus.M_valE_o,           m_m.val_e);
    check({tag, "_MvalA"}, bus.M_valA_o,           m_m.val_a);
    check({tag, "_MdstE"}, {60'd0, bus.M_dstE_o},  {60'd0, m_m.dst_e});
    check({tag, "_MdstM"}, {60'd0, bus.M_dstM_o},  {60'd0, m_m.dst_m});
  endtask

  // Called just after a rising edge with inputs set; returns just after the next rising edge
  task automatic step(input string tag);
    logic [63:0] ev;
    logic [2:0]  fl, ncc;
    logic        ec;
    logic [3:0]  ed;
    m_t          nm;
    ev = ref_alu(bus.fun_i, bus.aluA_i, bus.aluB_i);
    fl = ref_flags(bus.fun_i, bus.aluA_i, bus.aluB_i);
    ec = (bus.E_icode_i == 4'h2 || bus.E_icode_i == 4'h7) ? ref_cond(cc_m, bus.E_ifun_i) : 1'b0;
    ed = (bus.E_icode_i == 4'h2 && !ec) ? 4'hF : bus.E_dstE_i;
    ncc = (bus.E_icode_i == 4'h6 && !is_exc(bus.m_stat_i) && !is_exc(bus.W_stat_i)) ? fl : cc_m;
    if (bus.M_bubble_i)
      nm = bubble_m;
    else
      nm = '{bus.E_stat_i, bus.E_icode_i, ec, ev, bus.E_valA_i, ed, bus.E_dstM_i};
    @(negedge clk);
    obs_val = bus.e_valE_o;
    obs_dst = bus.e_dstE_o;
    obs_cnd = bus.e_cnd_o;
    check({tag, "_valE"}, obs_val, ev);
    check({tag, "_dstE"}, {60'd0, obs_dst}, {60'd0, ed});
    check({tag, "_cnd"},  {63'd0, obs_cnd}, {63'd0, ec});
    @(posedge clk);
    #1;
    cc_m = ncc;
    m_m  = nm;
    check_regs(tag);
  endtask

  task automatic idle();
    bus.aluA_i = '0; bus.aluB_i = '0; bus.fun_i = 4'd0;
    bus.E_icode_i = 4'h1; bus.E_ifun_i = 4'd0; bus.E_stat_i = 3'd1;
    bus.E_valA_i = '0; bus.E_dstE_i = 4'hF; bus.E_dstM_i = 4'hF;
    bus.m_stat_i = 3'd1; bus.W_stat_i = 3'd1; bus.M_bubble_i = 1'b0;
  endtask

  task automatic opq(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                     input logic [3:0] dst);
    idle();
    bus.E_icode_i = 4'h6; bus.fun_i = f; bus.aluA_i = a; bus.aluB_i = b; bus.E_dstE_i = dst;
  endtask

  task automatic cond_insn(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] dst);
    idle();
    bus.E_icode_i = icode; bus.E_ifun_i = ifun; bus.E_dstE_i = dst;
    bus.E_valA_i = 64'h1234; bus.aluA_i = 64'h1234;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return MAXP;
      3: return MINN;
      4: return ONES;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bubble_m = '{3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};

    tbl[0] = '{4'd1, 64'd5,      64'd5,      64'd0,                 3'b100};
    tbl[1] = '{4'd0, 64'd1,      MAXP,       MINN,                  3'b011};
    tbl[2] = '{4'd0, 64'd1,      ONES,       64'd0,                 3'b100};
    tbl[3] = '{4'd1, 64'd1,      MINN,       MAXP,                  3'b001};
    tbl[4] = '{4'd2, 64'hF0F0,   64'h0FF0,   64'h00F0,              3'b000};
    tbl[5] = '{4'd3, ONES,       64'd0,      ONES,                  3'b010};
    tbl[6] = '{4'd5, 64'd3,      64'd4,      64'd0,                 3'b100};
    tbl[7] = '{4'd1, MINN,       64'd0,      MINN,                  3'b011};
    tbl[8] = '{4'd0, MINN,       MINN,       64'd0,                 3'b101};

    // Reset state
    idle();
    rst_n = 1'b0;
    cc_m = 3'b100;
    m_m  = bubble_m;
    #7;
    check_regs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU / flag vectors
    for (int i = 0; i < 9; i++) begin
      opq(tbl[i].fun, tbl[i].a, tbl[i].b, 4'(i));
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_valE", i), obs_val, tbl[i].exp_val);
      check($sformatf("vec%0d_tbl_cc", i), {61'd0, bus.cc_o}, {61'd0, tbl[i].exp_cc});
    end

    // SUBQ 5-5 then je sees ZF through the register
    opq(4'd1, 64'd5, 64'd5, 4'd1);
    step("sub_eq");
    check("sub_eq_cc", {61'd0, bus.cc_o}, 64'd4);
    cond_insn(4'h7, 4'd3, 4'hF);
    step("je");
    check("je_cnd", {63'd0, obs_cnd}, 64'd1);
    check("je_Mcnd", {63'd0, bus.M_cnd_o}, 64'd1);

    // Signed overflow then cmovle: SF=1, OF=1 so LE = (SF^OF)|ZF = 0
    opq(4'd0, 64'd1, MAXP, 4'd1);
    step("add_ovf");
    check("add_ovf_cc", {61'd0, bus.cc_o}, 64'd3);
    cond_insn(4'h2, 4'd1, 4'd3);
    step("cmovle_ovf");
    check("cmovle_ovf_dstE", {60'd0, obs_dst}, 64'hF);

    // CC=000, cmovle not taken squashes dstE
    opq(4'd0, 64'd2, 64'd3, 4'd1);
    step("add_pos");
    check("add_pos_cc", {61'd0, bus.cc_o}, 64'd0);
    cond_insn(4'h2, 4'd1, 4'd3);
    step("cmovle_nt");
    check("cmovle_nt_cnd", {63'd0, obs_cnd}, 64'd0);
    check("cmovle_nt_dstE", {60'd0, obs_dst}, 64'hF);
    check("cmovle_nt_MdstE", {60'd0, bus.M_dstE_o}, 64'hF);

    // CC gating by downstream exceptions
    opq(4'd3, 64'd7, 64'd7, 4'd2);
    bus.m_stat_i = 3'd3;
    step("xor_madr");
    check("xor_madr_cc", {61'd0, bus.cc_o}, 64'd0);
    opq(4'd3, 64'd7, 64'd7, 4'd2);
    bus.W_stat_i = 3'd2;
    step("xor_whlt");
    check("xor_whlt_cc", {61'd0, bus.cc_o}, 64'd0);
    opq(4'd3, 64'd7, 64'd7, 4'd2);
    step("xor_aok");
    check("xor_aok_cc", {61'd0, bus.cc_o}, 64'd4);

    // Bubble into M does not block the CC update
    opq(4'd0, 64'h8, 64'h8, 4'd2);
    bus.M_bubble_i = 1'b1;
    step("bubble");
    check("bubble_Micode", {60'd0, bus.M_icode_o}, 64'd1);
    check("bubble_MvalE", bus.M_valE_o, 64'd0);
    check("bubble_MdstE", {60'd0, bus.M_dstE_o}, 64'hF);
    check("bubble_cc", {61'd0, bus.cc_o}, 64'd0);

    // Async reset mid-run with an OPQ in flight, no clock edge needed
    opq(4'd1, 64'd9, 64'd3, 4'd4);
    #3;
    rst_n = 1'b0;
    #1;
    cc_m = 3'b100;
    m_m  = bubble_m;
    check_regs("async_rst");
    #2;
    rst_n = 1'b1;
    step("post_rst");

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      idle();
      case ($urandom_range(0, 3))
        0: bus.E_icode_i = 4'h6;
        1: bus.E_icode_i = 4'h2;
        2: bus.E_icode_i = 4'h7;
        default: bus.E_icode_i = 4'($urandom_range(0, 15));
      endcase
      bus.fun_i    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      bus.E_ifun_i = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      bus.aluA_i   = rnd_operand();
      bus.aluB_i   = rnd_operand();
      bus.E_valA_i = {$urandom, $urandom};
      bus.E_stat_i = 3'($urandom_range(1, 4));
      bus.E_dstE_i = 4'($urandom_range(0, 15));
      bus.E_dstM_i = 4'($urandom_range(0, 15));
      bus.m_stat_i = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
      bus.W_stat_i = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
      bus.M_bubble_i = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
